// File: rtl/lmem_bank_sched_if.sv
// lmem_bank_sched_if
//   Bundles the requester-side request bus, the RAM bank drive and the
//   response channel of one local-memory bank scheduler.
//
//   Request side : req_valid, req_rw, req_addr, req_byteen, req_data, req_tag
//                  (flattened per requester), req_ready (one-hot grant)
//   Bank side    : bank_read, bank_write, bank_addr, bank_wren, bank_wdata,
//                  bank_rdata (valid the cycle after bank_read)
//   Response side: rsp_valid, rsp_idx, rsp_data, rsp_tag, rsp_ready
//
//   slave  : the scheduler
//   master : the surroundings (requesters, RAM macro, response consumer)
interface lmem_bank_sched_if #(
    parameter int NUM_REQS   = 4,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 16
);
    localparam int IDX_WIDTH = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
    localparam int BE_WIDTH  = DATA_WIDTH / 8;

    logic [NUM_REQS-1:0]            req_valid;
    logic [NUM_REQS-1:0]            req_rw;
    logic [NUM_REQS*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQS*BE_WIDTH-1:0]   req_byteen;
    logic [NUM_REQS*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQS*TAG_WIDTH-1:0]  req_tag;
    logic [NUM_REQS-1:0]            req_ready;

    logic                           bank_read;
    logic                           bank_write;
    logic [ADDR_WIDTH-1:0]          bank_addr;
    logic [BE_WIDTH-1:0]            bank_wren;
    logic [DATA_WIDTH-1:0]          bank_wdata;
    logic [DATA_WIDTH-1:0]          bank_rdata;

    logic                           rsp_valid;
    logic [IDX_WIDTH-1:0]           rsp_idx;
    logic [DATA_WIDTH-1:0]          rsp_data;
    logic [TAG_WIDTH-1:0]           rsp_tag;
    logic                           rsp_ready;

    modport slave (
        input  req_valid, req_rw, req_addr, req_byteen, req_data, req_tag,
        output req_ready,
        output bank_read, bank_write, bank_addr, bank_wren, bank_wdata,
        input  bank_rdata,
        output rsp_valid, rsp_idx, rsp_data, rsp_tag,
        input  rsp_ready
    );

    modport master (
        output req_valid, req_rw, req_addr, req_byteen, req_data, req_tag,
        input  req_ready,
        input  bank_read, bank_write, bank_addr, bank_wren, bank_wdata,
        output bank_rdata,
        input  rsp_valid, rsp_idx, rsp_data, rsp_tag,
        output rsp_ready
    );
endinterface

// File: rtl/lmem_bank_sched.sv
// lmem_bank_sched
//   Shares one single-port, synchronous-read local-memory bank between
//   NUM_REQS requesters. Round-robin arbitration among eligible requests,
//   one-cycle read-after-write bubble on the same address, and read data
//   returned through a 2-entry credit-managed response queue tagged with the
//   requester index.
//
//   Ports
//     clk            : clock
//     reset_n        : asynchronous active-low reset
//     bus            : lmem_bank_sched_if.slave (request, bank, response)
//     perf_conflicts : saturating count of cycles with more than one
//                      req_valid asserted
module lmem_bank_sched #(
    parameter int NUM_REQS   = 4,
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int TAG_WIDTH  = 16,
    parameter int CTR_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset_n,
    lmem_bank_sched_if.slave      bus,
    output logic [CTR_WIDTH-1:0]  perf_conflicts
);
    localparam int IDX_WIDTH = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;
    localparam int BE_WIDTH  = DATA_WIDTH / 8;

    typedef struct packed {
        logic [IDX_WIDTH-1:0]  idx;
        logic [TAG_WIDTH-1:0]  tag;
        logic [DATA_WIDTH-1:0] data;
    } rsp_t;

    // Arbitration state and RAW hazard tracking
    logic [IDX_WIDTH-1:0]  rr_ptr;
    logic                  last_wr_valid;
    logic [ADDR_WIDTH-1:0] last_wr_addr;

    // Read issued last cycle; its data is on bank_rdata now
    logic                  inf_valid;
    logic [IDX_WIDTH-1:0]  inf_idx;
    logic [TAG_WIDTH-1:0]  inf_tag;

    // Response queue
    rsp_t                  q_mem [2];
    logic                  q_rd_ptr;
    logic                  q_wr_ptr;
    logic [1:0]            q_count;

    logic [CTR_WIDTH-1:0]  conflict_cnt;

    logic [1:0]            occupancy;
    logic                  credit_ok;
    logic                  pop;
    logic                  push_store;
    logic                  pop_store;
    rsp_t                  push_ent;
    rsp_t                  head_ent;

    logic [NUM_REQS-1:0]   eligible;
    logic [NUM_REQS-1:0]   grant;
    logic                  grant_any;
    logic [IDX_WIDTH-1:0]  grant_idx;
    int                    cand;

    logic                  sel_rw;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [BE_WIDTH-1:0]   sel_wren;
    logic [DATA_WIDTH-1:0] sel_wdata;
    logic [TAG_WIDTH-1:0]  sel_tag;

    // ------------------------------------------------------------------
    // Response path. With the queue empty, the read data returning this
    // cycle is presented directly; if it is consumed right away it never
    // occupies a queue slot.
    // ------------------------------------------------------------------
    assign push_ent.idx  = inf_idx;
    assign push_ent.tag  = inf_tag;
    assign push_ent.data = bus.bank_rdata;

    assign head_ent      = (q_count != 2'd0) ? q_mem[q_rd_ptr] : push_ent;

    assign bus.rsp_valid = inf_valid || (q_count != 2'd0);
    assign bus.rsp_idx   = head_ent.idx;
    assign bus.rsp_tag   = head_ent.tag;
    assign bus.rsp_data  = head_ent.data;

    assign pop        = bus.rsp_valid && bus.rsp_ready;
    assign push_store = inf_valid && !((q_count == 2'd0) && pop);
    assign pop_store  = pop && (q_count != 2'd0);

    // A read may issue only if its response is guaranteed a slot: the read
    // in flight plus queued entries must leave room, counting a pop that
    // happens in this same cycle.
    assign occupancy = {1'b0, inf_valid} + q_count;
    assign credit_ok = (occupancy < 2'd2) || ((occupancy == 2'd2) && pop);

    // ------------------------------------------------------------------
    // Eligibility. Gated by reset_n so nothing is granted while the block
    // is held in reset.
    // ------------------------------------------------------------------
    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (bus.req_valid[i] && reset_n) begin
                if (bus.req_rw[i]) begin
                    eligible[i] = 1'b1;
                end else begin
                    eligible[i] = credit_ok &&
                        !(last_wr_valid &&
                          (bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH] == last_wr_addr));
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Round-robin search starting at rr_ptr; the first eligible wins.
    // ------------------------------------------------------------------
    always_comb begin
        grant     = '0;
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = 0;
        for (int k = 0; k < NUM_REQS; k++) begin
            cand = int'(rr_ptr) + k;
            if (cand >= NUM_REQS) begin
                cand = cand - NUM_REQS;
            end
            if (!grant_any && eligible[cand[IDX_WIDTH-1:0]]) begin
                grant_any                     = 1'b1;
                grant_idx                     = cand[IDX_WIDTH-1:0];
                grant[cand[IDX_WIDTH-1:0]]    = 1'b1;
            end
        end
    end

    // Granted requester's fields; zero when nothing is granted.
    always_comb begin
        sel_rw    = 1'b0;
        sel_addr  = '0;
        sel_wren  = '0;
        sel_wdata = '0;
        sel_tag   = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (grant[i]) begin
                sel_rw    = bus.req_rw[i];
                sel_addr  = bus.req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
                sel_wren  = bus.req_byteen[i*BE_WIDTH +: BE_WIDTH];
                sel_wdata = bus.req_data[i*DATA_WIDTH +: DATA_WIDTH];
                sel_tag   = bus.req_tag[i*TAG_WIDTH +: TAG_WIDTH];
            end
        end
    end

    assign bus.req_ready  = grant;
    assign bus.bank_write = grant_any && sel_rw;
    assign bus.bank_read  = grant_any && !sel_rw;
    assign bus.bank_addr  = sel_addr;
    assign bus.bank_wren  = sel_wren;
    assign bus.bank_wdata = sel_wdata;

    assign perf_conflicts = conflict_cnt;

    // ------------------------------------------------------------------
    // Sequential state
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr        <= '0;
            last_wr_valid <= 1'b0;
            last_wr_addr  <= '0;
            inf_valid     <= 1'b0;
            inf_idx       <= '0;
            inf_tag       <= '0;
            q_rd_ptr      <= 1'b0;
            q_wr_ptr      <= 1'b0;
            q_count       <= 2'd0;
            conflict_cnt  <= '0;
        end else begin
            if (grant_any) begin
                rr_ptr <= (grant_idx == IDX_WIDTH'(NUM_REQS - 1)) ? '0 : grant_idx + 1'b1;
            end

            // The bubble covers only the cycle right after a write.
            last_wr_valid <= bus.bank_write;
            if (bus.bank_write) begin
                last_wr_addr <= bus.bank_addr;
            end

            inf_valid <= bus.bank_read;
            if (bus.bank_read) begin
                inf_idx <= grant_idx;
                inf_tag <= sel_tag;
            end

            if (push_store) begin
                q_wr_ptr <= ~q_wr_ptr;
            end
            if (pop_store) begin
                q_rd_ptr <= ~q_rd_ptr;
            end
            q_count <= q_count + 2'(push_store) - 2'(pop_store);

            if (($countones(bus.req_valid) > 1) && (conflict_cnt != '1)) begin
                conflict_cnt <= conflict_cnt + 1'b1;
            end
        end
    end

    // Queue payload needs no reset; q_count qualifies it.
    always_ff @(posedge clk) begin
        if (push_store) begin
            q_mem[q_wr_ptr] <= push_ent;
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(push_store && !pop_store && (q_count == 2'd2)));

endmodule
